// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host transmitter types, command codes and timing helper
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      SHIFT,
      ACK,
      RELEASE,
      DONE,
      ERR
   } ps2_state_e;

   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

   function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned mhz);
      return us * mhz;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake and completion status bundle
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       ack_err;

   modport master (output tx_valid, tx_data, input tx_ready, busy, done, ack_err);
   modport slave  (input tx_valid, tx_data, output tx_ready, busy, done, ack_err);
endinterface

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - PS/2 pin synchronizer with clock falling-edge detect (SYNC_STAGES >= 2)
module ps2_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_ps2_clk,
   input  logic i_ps2_data,
   output logic o_clk_sync,
   output logic o_data_sync,
   output logic o_clk_fe
);

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_clk_prev;

   // Idle PS/2 lines float high, so reset the chain to 1 to avoid a phantom edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
         r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
      end
   end

   assign o_clk_sync  = r_clk_sync[SYNC_STAGES-1];
   assign o_data_sync = r_data_sync[SYNC_STAGES-1];
   assign o_clk_fe    = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (optional retries: PS2_HOST_TX_RETRY_EN)
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_MHZ          = 50,
   parameter int unsigned INHIBIT_US       = 120,
   parameter int unsigned START_TIMEOUT_US = 15000,
   parameter int unsigned FRAME_TIMEOUT_US = 2000,
   parameter int          SYNC_STAGES      = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   ps2_host_tx_if.slave      bus,
   input  logic              i_ps2_clk,
   input  logic              i_ps2_data,
   output logic              o_ps2_clk_oe,
   output logic              o_ps2_data_oe
);

   localparam int unsigned INH_CYC   = us_to_cycles(INHIBIT_US, CLK_MHZ);
   localparam int unsigned START_CYC = us_to_cycles(START_TIMEOUT_US, CLK_MHZ);
   localparam int unsigned FRAME_CYC = us_to_cycles(FRAME_TIMEOUT_US, CLK_MHZ);
   localparam int unsigned MAX_A     = (INH_CYC > START_CYC) ? INH_CYC : START_CYC;
   localparam int unsigned MAX_CYC   = (MAX_A > FRAME_CYC) ? MAX_A : FRAME_CYC;
   localparam int          CNT_W     = $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INH_CYC - 1);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYC - 1);

   ps2_state_e       r_state, w_nstate;
   logic [CNT_W-1:0] r_cnt, w_ncnt;
   logic [3:0]       r_idx, w_nidx;
   logic [8:0]       r_bits, w_nbits;
   logic             r_data_oe, w_ndata_oe;
   logic             w_fail;
   logic             w_clk_s, w_data_s, w_fe;
`ifdef PS2_HOST_TX_RETRY_EN
   logic [1:0]       r_retry, w_nretry;
`endif

   ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_ps2_clk   (i_ps2_clk),
      .i_ps2_data  (i_ps2_data),
      .o_clk_sync  (w_clk_s),
      .o_data_sync (w_data_s),
      .o_clk_fe    (w_fe)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_bits    <= '0;
         r_data_oe <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
         r_retry   <= '0;
`endif
      end else begin
         r_state   <= w_nstate;
         r_cnt     <= w_ncnt;
         r_idx     <= w_nidx;
         r_bits    <= w_nbits;
         r_data_oe <= w_ndata_oe;
`ifdef PS2_HOST_TX_RETRY_EN
         r_retry   <= w_nretry;
`endif
      end
   end

   // One counter serves inhibit, start timeout and frame timeout: the phases never overlap.
   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      w_nidx   = r_idx;
      w_nbits  = r_bits;
      w_fail   = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      w_nretry = r_retry;
`endif
      case (r_state)
         IDLE: begin
            if (bus.tx_valid) begin
               w_nbits  = {~^bus.tx_data, bus.tx_data};
               w_ncnt   = '0;
               w_nstate = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
               w_nretry = '0;
`endif
            end
         end
         INHIBIT: begin
            if (r_cnt == INH_LAST) begin
               w_ncnt   = '0;
               w_nstate = REQ;
            end else begin
               w_ncnt = r_cnt + 1'b1;
            end
         end
         REQ: begin
            // The device's first falling edge asks for d0; index tracks the bit on the line.
            if (w_fe) begin
               w_ncnt   = '0;
               w_nidx   = 4'd0;
               w_nstate = SHIFT;
            end else if (r_cnt == START_LAST) begin
               w_fail = 1'b1;
            end else begin
               w_ncnt = r_cnt + 1'b1;
            end
         end
         SHIFT: begin
            if (r_cnt == FRAME_LAST) begin
               w_fail = 1'b1;
            end else begin
               w_ncnt = r_cnt + 1'b1;
               if (w_fe) begin
                  if (r_idx == 4'd8) w_nstate = ACK;
                  else               w_nidx   = r_idx + 4'd1;
               end
            end
         end
         ACK: begin
            if (r_cnt == FRAME_LAST) begin
               w_fail = 1'b1;
            end else begin
               w_ncnt = r_cnt + 1'b1;
               if (w_fe) begin
                  if (w_data_s) w_fail   = 1'b1;
                  else          w_nstate = RELEASE;
               end
            end
         end
         RELEASE: begin
            if (w_clk_s && w_data_s) w_nstate = DONE;
         end
         DONE:    w_nstate = IDLE;
         ERR:     w_nstate = IDLE;
         default: w_nstate = IDLE;
      endcase

      if (w_fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
         if (r_retry != 2'd2) begin
            w_nretry = r_retry + 2'd1;
            w_ncnt   = '0;
            w_nstate = INHIBIT;
         end else begin
            w_nstate = ERR;
         end
`else
         w_nstate = ERR;
`endif
      end

      // Data is only ever pulled low for the start bit and for 0-valued frame bits.
      w_ndata_oe = (w_nstate == REQ) || ((w_nstate == SHIFT) && !w_nbits[w_nidx]);
   end

   assign bus.tx_ready  = (r_state == IDLE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = (r_state == DONE) || (r_state == ERR);
   assign bus.ack_err   = (r_state == ERR);
   assign o_ps2_clk_oe  = (r_state == INHIBIT);
   assign o_ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed vector bench for ps2_host_tx with a behavioural PS/2 device
`timescale 1ns/1ps
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int H = 10;
`ifdef PS2_HOST_TX_RETRY_EN
   localparam int FAIL_ATTEMPTS = 3;
`else
   localparam int FAIL_ATTEMPTS = 1;
`endif

   typedef struct {
      logic [7:0] data;
      bit         nack;
      bit         exp_par;
      bit         exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;
   logic clk_oe, data_oe;
   wire  ps2_clk_line, ps2_data_line;

   ps2_host_tx_if bus();

   assign ps2_clk_line  = dev_clk & ~clk_oe;
   assign ps2_data_line = dev_data & ~data_oe;

   ps2_host_tx #(
      .CLK_MHZ(50), .INHIBIT_US(120), .START_TIMEOUT_US(10),
      .FRAME_TIMEOUT_US(2000), .SYNC_STAGES(2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .i_ps2_clk     (ps2_clk_line),
      .i_ps2_data    (ps2_data_line),
      .o_ps2_clk_oe  (clk_oe),
      .o_ps2_data_oe (data_oe)
   );

   always #10 clk = ~clk;

   int n_vec = 0, n_err = 0;
   int done_cnt = 0, inh_run = 0, last_inh = 0, idle_drive = 0;
   logic last_err = 1'b0;

   always @(negedge clk) begin
      if (bus.done) begin
         done_cnt = done_cnt + 1;
         last_err = bus.ack_err;
      end
      if (clk_oe) inh_run = inh_run + 1;
      else if (inh_run != 0) begin
         last_inh = inh_run;
         inh_run  = 0;
      end
      if (bus.tx_ready && data_oe) idle_drive = idle_drive + 1;
   end

   initial begin
      #4ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = b;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   // Device side: wait for request, clock out 10 bits sampling on rising edges, then ack/nack.
   task automatic dev_xfer(input bit nack, input int stop_at, output logic [7:0] got,
                           output logic par, output logic start_b, output logic stop_b,
                           output bit seen);
      int n;
      got = '0; par = 1'b0; start_b = 1'b1; stop_b = 1'b0; seen = 1'b0;
      n = 0;
      while (!(data_oe && !clk_oe) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) return;
      seen    = 1'b1;
      start_b = ps2_data_line;
      repeat (20) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         dev_clk = 1'b0;
         repeat (H) @(negedge clk);
         if (i == stop_at) return;
         dev_clk = 1'b1;
         if (i < 8)       got[i] = ps2_data_line;
         else if (i == 8) par    = ps2_data_line;
         else             stop_b = ps2_data_line;
         repeat (H) @(negedge clk);
      end
      if (!nack) dev_data = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
      dev_data = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_done(input int d0);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("done timeout", (n < 20000), 1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int d0;
      logic [7:0] got;
      logic par, sb, pb;
      bit seen;
      d0 = done_cnt;
      send(v.data);
      for (int a = 0; a < (v.nack ? FAIL_ATTEMPTS : 1); a++)
         dev_xfer(v.nack, -1, got, par, sb, pb, seen);
      wait_done(d0);
      repeat (5) @(negedge clk);
      check({tag, " request seen"}, seen, 1);
      check({tag, " start bit"}, sb, 0);
      check({tag, " data byte"}, got, v.data);
      check({tag, " parity"}, par, v.exp_par);
      check({tag, " stop bit"}, pb, 1);
      check({tag, " inhibit cycles"}, last_inh, 6000);
      check({tag, " done pulses"}, done_cnt - d0, 1);
      check({tag, " ack_err"}, last_err, v.exp_err);
      check({tag, " lines/ready after"}, {bus.tx_ready, clk_oe, data_oe}, 3'b100);
   endtask

   vec_t vecs[5];

   initial begin
      int d0, n;
      logic [7:0] got;
      logic par, sb, pb;
      bit seen;
      vec_t vf4;

      vecs[0] = '{data: PS2_CMD_SET_LEDS, nack: 1'b0, exp_par: 1'b1, exp_err: 1'b0};
      vecs[1] = '{data: 8'h01,            nack: 1'b0, exp_par: 1'b0, exp_err: 1'b0};
      vecs[2] = '{data: PS2_CMD_RESET,    nack: 1'b0, exp_par: 1'b1, exp_err: 1'b0};
      vecs[3] = '{data: PS2_RSP_ACK,      nack: 1'b1, exp_par: 1'b1, exp_err: 1'b1};
      vecs[4] = '{data: PS2_CMD_ENABLE,   nack: 1'b0, exp_par: 1'b0, exp_err: 1'b0};

      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("reset outputs", {bus.tx_ready, bus.busy, bus.done, bus.ack_err, clk_oe, data_oe}, 6'b100000);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Clock glitch while idle must not start anything
      dev_clk = 1'b0;
      repeat (3) @(negedge clk);
      dev_clk = 1'b1;
      repeat (20) @(negedge clk);
      check("idle glitch", {bus.tx_ready, bus.busy, bus.done, data_oe, clk_oe, 27'(done_cnt)}, 32'h8000_0000);

      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Device never clocks: start timeout 500 cycles after request
      d0 = done_cnt;
      send(PS2_CMD_ENABLE);
      n = 0;
      while (!(data_oe && !clk_oe) && n < 10000) begin @(negedge clk); n++; end
      n = 0;
      while (!bus.done && !clk_oe && n < 2000) begin @(negedge clk); n++; end
      check("start timeout latency", n, 500);
`ifndef PS2_HOST_TX_RETRY_EN
      check("start timeout status", {bus.done, bus.ack_err, clk_oe, data_oe}, 4'b1100);
`endif
      wait_done(d0);
      repeat (3) @(negedge clk);
      check("start timeout ack_err", last_err, 1);
      check("start timeout lines", {clk_oe, data_oe}, 2'b00);

      // Reset while bit 4 of 0xED (a zero) is on the line
      d0 = done_cnt;
      send(PS2_CMD_SET_LEDS);
      dev_xfer(1'b0, 4, got, par, sb, pb, seen);
      check("mid-frame bit4 driven", data_oe, 1);
      #3 rst_n = 1'b0;
      #1 check("async release", {clk_oe, data_oe}, 2'b00);
      dev_clk = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("after reset", {bus.tx_ready, bus.busy, bus.done, 29'(done_cnt - d0)}, 32'h8000_0000);
      vf4 = '{data: PS2_CMD_ENABLE, nack: 1'b0, exp_par: 1'b0, exp_err: 1'b0};
      run_vec(vf4, "post-reset F4");

      // Second byte offered while busy must be dropped
      d0 = done_cnt;
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = PS2_CMD_SET_LEDS;
      @(negedge clk);
      bus.tx_data  = 8'h01;
      repeat (100) @(negedge clk);
      bus.tx_valid = 1'b0;
      dev_xfer(1'b0, -1, got, par, sb, pb, seen);
      wait_done(d0);
      repeat (50) @(negedge clk);
      check("busy byte ignored data", got, 8'hED);
      check("busy byte ignored done", done_cnt - d0, 1);
      check("busy byte no restart", {bus.tx_ready, clk_oe}, 2'b10);

`ifdef PS2_HOST_TX_RETRY_EN
      d0 = done_cnt;
      send(PS2_CMD_RESET);
      dev_xfer(1'b1, -1, got, par, sb, pb, seen);
      dev_xfer(1'b1, -1, got, par, sb, pb, seen);
      check("retry busy between", {bus.busy, 28'(done_cnt - d0)}, 29'h1000_0000);
      dev_xfer(1'b0, -1, got, par, sb, pb, seen);
      wait_done(d0);
      repeat (5) @(negedge clk);
      check("retry data", got, 8'hFF);
      check("retry single done", done_cnt - d0, 1);
      check("retry ack_err", last_err, 0);
`endif

      check("data driven in idle", idle_drive, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter: the outbound counterpart of the keyboard receiver that produces ps2_scancode/ps2_ascii. It sends command bytes to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) and 0xFF (reset), using the open-collector host request protocol. It sits beside the receiver in the board wrapper and drives the PS/2 lines through open-drain enables. Its busy output tells the receiver to ignore the line while a transmission is in progress.

Parameters:
CLK_MHZ, 50, system clock frequency in MHz; all time constants scale by it.
INHIBIT_US, 120, time the host holds PS/2 clock low before the start bit (protocol minimum is 100).
START_TIMEOUT_US, 15000, maximum wait after the request for the device's first falling clock edge.
FRAME_TIMEOUT_US, 2000, maximum time from the first device clock edge to the acknowledge bit.
SYNC_STAGES, 2, number of flip-flops in the synchronizer on ps2_clk_i and ps2_data_i.

Ports:
clk  in  1  system clock; everything is on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
tx_valid  in  1  command byte offered.
tx_data  in  8  command byte.
tx_ready  out  1  high only in IDLE; the byte is accepted when tx_valid && tx_ready.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at the end of each transaction.
ack_err  out  1  valid with done: 1 = NACK or timeout, 0 = device acknowledged.
ps2_clk_i  in  1  raw PS/2 clock pin.
ps2_data_i  in  1  raw PS/2 data pin.
ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release.
ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.

Behaviour:
- Reset values: state IDLE, tx_ready=1, busy=0, done=0, ack_err=0, both _oe=0, counters=0. Reset mid-frame releases both lines immediately (asynchronously).
- Inputs pass through a SYNC_STAGES synchronizer. A falling edge (fe) is previous-synced=1 and current-synced=0. fe is one cycle wide and is delayed SYNC_STAGES+1 cycles from the pin.
- Accept: in IDLE, tx_valid=1 latches tx_data and computes parity = ~^tx_data (odd parity). Next state is INHIBIT. A tx_valid outside IDLE is ignored, not queued.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_US*CLK_MHZ cycles (6000 by default).
- On terminal count, go to REQ: data_oe=1 (start bit) and clk_oe=0 in the same cycle.
- REQ: wait for fe, then go to SHIFT with bit index 0. If START_TIMEOUT_US*CLK_MHZ cycles pass without fe, go to ERR.
- SHIFT: on each fe, present the next bit as data_oe = ~bit.
  - Index 0-7: d0..d7, LSB first.
  - Index 8: parity.
  - Index 9: data_oe=0 (stop bit, line released).
  - After the fe that presents the stop bit, go to ACK.
- ACK: on the next fe, sample the synced data. 0 = ack OK; 1 = NACK, go to ERR.
- Frame timer: starts at the first fe and is active in SHIFT and ACK. Expiry (FRAME_TIMEOUT_US*CLK_MHZ cycles) goes to ERR.
- RELEASE: wait until synced clk=1 and synced data=1, then go to DONE.
- DONE: done=1, ack_err=0 for one cycle, then IDLE.
- ERR: both _oe=0; done=1, ack_err=1 for one cycle, then IDLE.
- Counter width is $clog2 of the largest cycle constant (750000 cycles, 20 bits).
- A glitch on ps2_clk_i in IDLE has no effect. Data must never be driven low while in IDLE.

Optional Feature:
PS2_HOST_TX_RETRY_EN.
- Defined: on a NACK or either timeout, re-enter INHIBIT with the latched byte, up to 2 retries. done/ack_err are reported only after success or after the 3rd failed attempt. busy stays high throughout.
- Undefined: the first failure goes straight to ERR, and the retry counter is not synthesized.

Decomposition:
- Package ps2_pkg holds:
  - The state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE, DONE, ERR).
  - Command constants (PS2_CMD_SET_LEDS=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF, PS2_RSP_ACK=8'hFA).
  - A function that converts microseconds to cycles.
- Sub-module ps2_sync_edge: synchronizer plus falling-edge detector, shared with the receiver.

Test Plan:
- tx_data=8'hED, device model acks → bits on the line 1,0,1,1,0,1,1,1, parity 1, stop 1. done with ack_err=0. clk_oe high for exactly 6000 cycles.
- tx_data=8'h01 → parity 0. tx_data=8'hFF → parity 1. Device model checks framing.
- Device drives data=1 on the ack clock → done, ack_err=1. Both _oe=0 afterwards.
- Device never clocks, with START_TIMEOUT_US=10 → done with ack_err=1 at 500 cycles after REQ. Lines are released.
- rst_n asserted in SHIFT at bit 4 → both _oe=0 immediately, tx_ready=1 and done=0 after release. A new 0xF4 then completes normally.
- tx_valid held high during busy with a second byte → second byte ignored. With PS2_HOST_TX_RETRY_EN, two NACKs then an ACK → a single done with ack_err=0.
